// File: rtl/icache_line_refill.sv
// rtl/icache_line_refill.sv - direct-mapped instruction cache with word-serial line refill
//
// Purpose: answers IF fetches combinationally on a hit; on a miss stalls IF and
// refills the whole line from backing memory, one outstanding word request at a time.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   inst_mem_read_addr/_enable  fetch request from IF
//   inst_mem_read_data/_valid   fetched word, valid on a same-cycle hit
//   inst_mem_stall              hold IF's pc
//   invalidate                  pulse: clear every line valid bit
//   mem_req_valid/_ready/_addr  backing-memory word request handshake
//   mem_resp_valid/_data        backing-memory response word
module icache_line_refill #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_mem_read_addr,
    input  logic        inst_mem_read_enable,
    output logic [31:0] inst_mem_read_data,
    output logic        inst_mem_read_valid,
    output logic        inst_mem_stall,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int IW = $clog2(LINES);
    localparam int OB = OW + 2;
    localparam int TW = 32 - OB - IW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [LINES-1:0]    r_valid;
    logic [TW-1:0]       r_tag  [LINES];
    logic [31:0]         r_data [LINES*WORDS_PER_LINE];
    logic [TW+IW-1:0]    r_refill_addr;   // {tag, index} of the line being refilled
    logic [OW-1:0]       r_k;
    logic                r_inv_pending;

    logic [TW-1:0]       w_tag;
    logic [IW-1:0]       w_index;
    logic [OW-1:0]       w_offset;
    logic                w_lookup;
    logic                w_hit;
    logic                w_miss;
    logic [IW-1:0]       w_refill_index;
    logic [TW-1:0]       w_refill_tag;
    logic                w_last;
    logic                w_fill;
    logic                w_unused_addr_bits;

    assign w_tag              = inst_mem_read_addr[31:OB+IW];
    assign w_index            = inst_mem_read_addr[OB+IW-1:OB];
    assign w_offset           = inst_mem_read_addr[OB-1:2];
    assign w_unused_addr_bits = ^inst_mem_read_addr[1:0];

    assign w_lookup       = (r_state == S_IDLE) && inst_mem_read_enable;
    assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss         = w_lookup && !w_hit;
    assign w_refill_index = r_refill_addr[IW-1:0];
    assign w_refill_tag   = r_refill_addr[TW+IW-1:IW];
    assign w_last         = (r_k == OW'(WORDS_PER_LINE - 1));
    // A response is only consumed in WAIT; anything else is dropped.
    assign w_fill         = (r_state == S_WAIT) && mem_resp_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_next_state = S_REQ;
            S_REQ:   if (mem_req_ready) w_next_state = S_WAIT;
            S_WAIT:  if (mem_resp_valid) w_next_state = w_last ? S_IDLE : S_REQ;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        inst_mem_read_valid = w_lookup && w_hit;
        inst_mem_stall      = (r_state != S_IDLE) || w_miss;
        inst_mem_read_data  = r_data[{w_index, w_offset}];
        mem_req_valid       = (r_state == S_REQ);
        mem_req_addr        = '0;
        if (r_state == S_REQ) begin
            mem_req_addr = {r_refill_addr, r_k, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid       <= '0;
            r_inv_pending <= 1'b0;
            r_k           <= '0;
            r_refill_addr <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_miss) begin
                r_refill_addr <= {w_tag, w_index};
                r_k           <= '0;
            end
            // The lookup above already used the pre-clear valid bits.
            if (invalidate) begin
                r_valid <= '0;
            end else if (w_miss) begin
                r_valid[w_index] <= 1'b0;
            end
        end else begin
            if (invalidate) begin
                r_inv_pending <= 1'b1;
            end
            if (w_fill) begin
                if (w_last) begin
                    // A flush seen during the refill also kills the fresh line.
                    if (r_inv_pending || invalidate) begin
                        r_valid       <= '0;
                        r_inv_pending <= 1'b0;
                    end else begin
                        r_valid[w_refill_index] <= 1'b1;
                    end
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (reset && w_fill) begin
            r_data[{w_refill_index, r_k}] <= mem_resp_data;
            if (w_last) begin
                r_tag[w_refill_index] <= w_refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_icache_line_refill.sv
// tb/tb_icache_line_refill.sv - scoreboard bench for icache_line_refill
module tb_icache_line_refill;

    localparam int LINES = 16;
    localparam int WPL   = 4;
    localparam int OB    = $clog2(WPL) + 2;
    localparam int IW    = $clog2(LINES);

    logic        clk;
    logic        reset;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic        invalidate;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    icache_line_refill #(.LINES(LINES), .WORDS_PER_LINE(WPL)) dut (
        .clk                  (clk),
        .reset                (reset),
        .inst_mem_read_addr   (rd_addr),
        .inst_mem_read_enable (rd_en),
        .inst_mem_read_data   (rd_data),
        .inst_mem_read_valid  (rd_valid),
        .inst_mem_stall       (stall),
        .invalidate           (invalidate),
        .mem_req_valid        (mem_req_valid),
        .mem_req_ready        (mem_req_ready),
        .mem_req_addr         (mem_req_addr),
        .mem_resp_valid       (mem_resp_valid),
        .mem_resp_data        (mem_resp_data)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int          n_pass = 0;
    int          n_total = 0;
    int          n_accept = 0;
    int          ready_hold = 0;
    int          resp_delay = 0;
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_data_q[$];
    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];

    // Backing memory: word at byte address A holds A + 0x100.
    initial begin : responder
        int          hold_cnt;
        int          resp_cnt;
        bit          prev_acc;
        bit          resp_pend;
        logic [31:0] held_addr;
        logic [31:0] prev_addr;
        logic [31:0] resp_addr;
        logic [31:0] e;
        hold_cnt = 0; resp_cnt = 0; prev_acc = 0; resp_pend = 0;
        held_addr = 0; prev_addr = 0; resp_addr = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        forever begin
            @(negedge clk);
            if (prev_acc) begin
                n_accept++;
                n_total++;
                if (exp_req_q.size() == 0) begin
                    $display("FAIL req_order: unexpected request addr %h", prev_addr);
                end else begin
                    e = exp_req_q.pop_front();
                    if (prev_addr !== e) $display("FAIL req_order: got %h want %h", prev_addr, e);
                    else n_pass++;
                end
                resp_pend = 1; resp_cnt = resp_delay; resp_addr = prev_addr;
            end
            if (resp_pend && resp_cnt == 0) begin
                mem_resp_valid = 1; mem_resp_data = resp_addr + 32'h100; resp_pend = 0;
            end else begin
                mem_resp_valid = 0;
                if (resp_pend) resp_cnt--;
            end
            #1;
            prev_acc = 0;
            if (mem_req_valid === 1'b1) begin
                if (hold_cnt == 0) begin
                    held_addr = mem_req_addr;
                end else begin
                    n_total++;
                    if (mem_req_addr !== held_addr) $display("FAIL req_addr_stable: got %h want %h", mem_req_addr, held_addr);
                    else n_pass++;
                end
                if (hold_cnt < ready_hold) begin
                    mem_req_ready = 0; hold_cnt++;
                end else begin
                    mem_req_ready = 1; hold_cnt = 0;
                    prev_acc = reset; prev_addr = mem_req_addr;
                end
            end else begin
                mem_req_ready = 0; hold_cnt = 0;
            end
        end
    end

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
    endtask

    task automatic fetch(input logic [31:0] a, input int extra);
        int          idx;
        int          n_ref;
        int          stalls;
        int          exp_stall;
        bit          done;
        logic [31:0] tg;
        logic [31:0] base;
        logic [31:0] ed;
        idx   = int'((a >> OB) & (LINES - 1));
        tg    = a >> (OB + IW);
        n_ref = ((m_valid[idx] && m_tag[idx] == tg) ? 0 : 1) + extra;
        base  = a & ~32'(WPL * 4 - 1);
        for (int r = 0; r < n_ref; r++)
            for (int w = 0; w < WPL; w++) exp_req_q.push_back(base + 32'(4 * w));
        exp_data_q.push_back((a & ~32'h3) + 32'h100);
        m_valid[idx] = 1; m_tag[idx] = tg;
        exp_stall = n_ref * (1 + WPL * (2 + ready_hold + resp_delay));
        @(negedge clk);
        rd_addr = a; rd_en = 1;
        stalls = 0; done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            #1;
            if (rd_valid === 1'b1) done = 1;
            else begin
                if (stall === 1'b1) stalls++;
                @(negedge clk);
            end
        end
        ed = exp_data_q.pop_front();
        n_total++;
        if (!done) $display("FAIL fetch_timeout: addr %h no valid, want valid within budget", a);
        else begin
            n_pass++;
            n_total++;
            if (rd_data !== ed) $display("FAIL fetch_data: addr %h got %h want %h", a, rd_data, ed);
            else n_pass++;
        end
        n_total++;
        if (stalls != exp_stall) $display("FAIL stall_cycles: addr %h got %0d want %0d", a, stalls, exp_stall);
        else n_pass++;
        n_total++;
        if (exp_req_q.size() != 0) $display("FAIL missing_reqs: addr %h got %0d left want 0", a, exp_req_q.size());
        else n_pass++;
        exp_req_q.delete();
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; rd_en = 0; invalidate = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        clear_model();
        exp_req_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); else n_pass++;
    endtask

    task automatic test_enable_low();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            rd_addr = $urandom; rd_en = 0;
            #1;
            n_total++; if (stall !== 1'b0) $display("FAIL idle_stall: cycle %0d got %b want 0", c, stall); else n_pass++;
            n_total++; if (rd_valid !== 1'b0) $display("FAIL idle_valid: cycle %0d got %b want 0", c, rd_valid); else n_pass++;
            n_total++; if (mem_req_valid !== 1'b0) $display("FAIL idle_req: cycle %0d got %b want 0", c, mem_req_valid); else n_pass++;
        end
    endtask

    task automatic test_first_fill();
        fetch(32'h0, 0);
        fetch(32'h4, 0);
        fetch(32'hC, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h100, 0);
        fetch(32'h108, 0);
        fetch(32'h000, 0);
    endtask

    task automatic test_backpressure();
        int start;
        ready_hold = 5; resp_delay = 3;
        start = n_accept;
        fetch(32'h234, 0);
        n_total++;
        if (n_accept - start != WPL) $display("FAIL accept_count: got %0d want %0d", n_accept - start, WPL);
        else n_pass++;
        ready_hold = 0; resp_delay = 0;
        fetch(32'h238, 0);
    endtask

    task automatic test_invalidate_idle();
        fetch(32'h40, 0);
        @(negedge clk);
        invalidate = 1;
        @(negedge clk);
        invalidate = 0;
        clear_model();
        fetch(32'h40, 0);
    endtask

    task automatic test_invalidate_wait();
        int  start;
        bit  pulsed;
        start = n_accept; pulsed = 0;
        fork
            fetch(32'h80, 1);
            begin
                for (int c = 0; c < 200 && !pulsed; c++) begin
                    @(negedge clk);
                    #1;
                    if (n_accept > start && stall === 1'b1 && mem_req_valid === 1'b0) begin
                        invalidate = 1; pulsed = 1;
                        @(negedge clk);
                        invalidate = 0;
                    end
                end
            end
        join
        n_total++; if (!pulsed) $display("FAIL inv_wait_pulse: got no WAIT want WAIT state seen"); else n_pass++;
        clear_model();
        m_valid[8] = 1; m_tag[8] = 32'h0;
        fetch(32'h84, 0);
        fetch(32'h0, 0);
    endtask

    task automatic test_reset_mid_refill();
        int start;
        bit seen;
        resp_delay = 2;
        for (int w = 0; w < WPL; w++) exp_req_q.push_back(32'h3A0 + 32'(4 * w));
        start = n_accept; seen = 0;
        @(negedge clk);
        rd_addr = 32'h3A4; rd_en = 1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            #2;
            if (n_accept == start + 3) seen = 1;
        end
        n_total++; if (!seen) $display("FAIL rst_mid_reach: got %0d accepts want 3", n_accept - start); else n_pass++;
        @(negedge clk);
        reset = 0; rd_en = 0;
        @(negedge clk);
        reset = 1;
        #1;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL rst_mid_req: got %b want 0", mem_req_valid); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rst_mid_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (mem_req_addr !== 32'h0) $display("FAIL rst_mid_addr: got %h want 0", mem_req_addr); else n_pass++;
        clear_model();
        exp_req_q.delete();
        @(negedge clk);
        #1;
        n_total++; if (mem_req_valid !== 1'b0 || stall !== 1'b0) $display("FAIL late_resp: got req %b stall %b want 0 0", mem_req_valid, stall); else n_pass++;
        resp_delay = 0;
        fetch(32'h3A4, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 95)) * 32'h4 + ((i % 3 == 0) ? 32'h400 : 32'h0);
            fetch(a, 0);
        end
    endtask

    initial begin
        reset = 0; rd_addr = 0; rd_en = 0; invalidate = 0;
        test_reset();
        test_enable_low();
        test_first_fill();
        test_conflict();
        test_backpressure();
        test_invalidate_idle();
        test_invalidate_wait();
        test_reset_mid_refill();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_line_refill.md
# icache_line_refill

Direct-mapped instruction cache sitting between the IF stage's instruction-fetch port and the backing instruction memory. It answers fetch reads in the same cycle on a hit. On a miss it holds IF with a stall, refills the whole line from backing memory one word at a time over a valid/ready request and response handshake, then resumes. It also supports a whole-cache invalidate for instruction-stream flushes.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `inst_mem_read_addr`  in  32  fetch byte address from IF; bits [1:0] ignored.
- `inst_mem_read_enable`  in  1  fetch request this cycle.
- `inst_mem_read_data`  out  32  fetched instruction; valid only when `inst_mem_read_valid`=1.
- `inst_mem_read_valid`  out  1  hit, and data delivered this cycle.
- `inst_mem_stall`  out  1  IF must hold `pc`; OR'd into IF's stall.
- `invalidate`  in  1  single-cycle pulse that clears all line valid bits.
- `mem_req_valid`  out  1  backing-memory word read request.
- `mem_req_ready`  in  1  backing memory accepts the request.
- `mem_req_addr`  out  32  word-aligned byte address of the request.
- `mem_resp_valid`  in  1  response word present.
- `mem_resp_data`  in  32  response word.

## Operation
- Address split: offset `[OB-1:2]`, where OB = log2(WORDS_PER_LINE)+2. Index is the next log2(LINES) bits. Tag is the remaining upper bits.
- Storage: per line one valid bit, one tag and WORDS_PER_LINE data words. Read is combinational (flop or LUT array).
- Hit: enable=1, FSM in IDLE, line valid, and tag matches.
  - Outputs in the same cycle: valid=1, stall=0, data = stored word.
- Miss: enable=1 in IDLE with no hit.
  - Same cycle: valid=0, stall=1.
  - Capture tag and index into `refill_addr`, clear the line's valid bit, and go to REQ with word counter k=0.
- Enable=0 in IDLE: valid=0, stall=0, no state change.
- FSM states:
  - IDLE: lookup as above.
  - REQ: `mem_req_valid`=1 and `mem_req_addr` = line base + 4·k. On `mem_req_ready`=1, go to WAIT. Address and valid stay stable until accepted.
  - WAIT: `mem_req_valid`=0. On `mem_resp_valid`=1, write `mem_resp_data` to word k.
    - If k = WORDS_PER_LINE−1: set the tag, set valid, go to IDLE.
    - Otherwise: k+1, go to REQ.
- Only one request is ever outstanding. Words are refilled in ascending order starting at offset 0, with no critical-word-first.
- `inst_mem_stall`=1 and `inst_mem_read_valid`=0 in every non-IDLE state, regardless of enable or address.
- A refill always completes for the captured line even if IF's address changes meanwhile.
- `mem_resp_valid` outside WAIT is ignored and dropped.
- `invalidate`:
  - In IDLE: all valid bits clear at the next edge. The lookup in that same cycle still uses the pre-clear state.
  - In REQ or WAIT: set `inv_pending`. The refill completes, then at the final write all valid bits are cleared, including the freshly refilled line, and `inv_pending` is cleared.
- Reset (`reset`=0 at an edge) clears all valid bits, `inv_pending` and k, and sets FSM=IDLE. This applies mid-refill too: the refill is aborted, and a late response arriving after reset is dropped. Tag and data arrays are not reset.

## Timing
- Reset values: `inst_mem_read_valid`=0, `mem_req_valid`=0, `mem_req_addr`=0. `inst_mem_stall`=0 when enable=0. `inst_mem_read_data` is don't-care.
- Hit latency: 0 cycles (combinational from address).
- Miss penalty with zero-wait memory (ready=1 always, response in the cycle after acceptance):
  - Miss cycle in IDLE: 1.
  - REQ/WAIT pair: 2 per word.
  - Return to IDLE and hit: +1.
  - Total stall = 1 + 2·WORDS_PER_LINE cycles (9 at the default).
- `mem_req_valid` is registered (a state decode only). It never asserts in the miss-detect cycle.

## Test plan
- Reset, then fetch 0x0. Required: stall in that cycle, then requests to 0x0, 0x4, 0x8, 0xC in order. Data returned = address+0x100. After 9 stall cycles, data=0x100 with valid=1. Fetch 0x4 next: hit in the same cycle, data 0x104.
- Conflict: fill 0x000, then fetch 0x100 (same index, new tag). Required: refill at 0x100 to 0x10C. A refetch of 0x000 then misses again.
- Backpressure: hold `mem_req_ready`=0 for 5 cycles in REQ. Required: `mem_req_addr` stable, and exactly one acceptance per word. Delay responses by 3 cycles: stall extends accordingly, with no duplicate writes.
- Invalidate in IDLE after filling 0x0. Required: the next fetch of 0x0 misses. Invalidate pulsed during WAIT of a refill. Required: the refill completes, then the same address misses again on return to IDLE.
- Reset low during WAIT of word 2. Required: FSM IDLE and `mem_req_valid`=0 after the edge. A response pulse arriving one cycle later is ignored, and the next fetch of that line misses.
- Enable=0 for 10 cycles after reset. Required: stall=0, valid=0 and `mem_req_valid`=0 throughout.
